// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and bit-timing helpers.
// The RX side uses the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int cnt_width(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_fifo.sv
// Synchronous circular FIFO with fall-through read data and registered occupancy.
module uart_tx_fifo_cfg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // Guard here too so a misbehaving parent can never overwrite or underflow.
  assign do_push = i_push && (level_q != FULL);
  assign do_pop  = i_pop && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_level = level_q;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Parametrised UART transmitter fed by a small FIFO; frames leave back-to-back.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_IDLE   | line high, waiting for a FIFO entry
//   S_START  | start bit (low) for one bit time
//   S_DATA   | DATA_BITS data bits, LSB first
//   S_PARITY | parity bit (only with UART_TX_PARITY_EN)
//   S_STOP   | STOP_BITS stop bits high, then next word or idle
module uart_tx_fifo_cfg #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_tx_valid,
  input  logic [DATA_BITS-1:0]        i_tx_data,
  output logic                        o_tx_ready,
  output logic                        o_txd,
  output logic                        o_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
  import uart_pkg::*;

  localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CW  = cnt_width(CPB);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST      = CW'(CPB - 1);
  localparam logic [3:0]    IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    IDX_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL      = LW'(FIFO_DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo_cfg: STOP_BITS must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_baud
    $error("uart_tx_fifo_cfg: CLOCK_FREQ/BAUD_RATE must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_cfg: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_fifo_cfg: PARITY_ODD must be 0 or 1");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q;
  logic                 bit_done, take, pop, push;
  logic [DATA_BITS-1:0] fifo_data;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign o_tx_ready = (o_fifo_level != LVL_FULL);
  assign push       = i_tx_valid && o_tx_ready;
  assign bit_done   = (cnt_q == CNT_LAST);

  uart_tx_fifo_cfg_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (i_tx_data),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_level (o_fifo_level)
  );

  // The line is driven from state_q and registered, so it trails the FSM by one clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    take    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (o_fifo_level != '0) take = 1'b1;
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd_d = par_q;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
            if (o_fifo_level != '0) take = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    if (take) begin
      pop     = 1'b1;
      shift_d = fifo_data;
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = (PARITY_ODD != 0) ? ~^fifo_data : ^fifo_data;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= (state_q != S_IDLE) || (o_fifo_level != '0);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_txd     = txd_q;
  assign o_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg at 10 clocks per bit; expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_fifo_cfg;

  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB8  = 10 + P;
  localparam int NB72 = 10 + P;
  localparam int FLEN = 100 + 10 * P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, v, rst2, v2;
  logic [7:0] d;
  logic [6:0] d2;
  logic       rdy0, txd0, busy0, rdy1, txd1, busy1, rdy2, txd2, busy2;
  logic [2:0] lvl0, lvl1, lvl2;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .PARITY_ODD(0)) u_even (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(v), .i_tx_data(d),
    .o_tx_ready(rdy0), .o_txd(txd0), .o_tx_busy(busy0), .o_fifo_level(lvl0));

  uart_tx_fifo_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .PARITY_ODD(1)) u_odd (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(v), .i_tx_data(d),
    .o_tx_ready(rdy1), .o_txd(txd1), .o_tx_busy(busy1), .o_fifo_level(lvl1));

  uart_tx_fifo_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .STOP_BITS(2),
                     .FIFO_DEPTH(4), .PARITY_ODD(0)) u_72 (
    .i_clk(clk), .i_rst(rst2), .i_tx_valid(v2), .i_tx_data(d2),
    .o_tx_ready(rdy2), .o_txd(txd2), .o_tx_busy(busy2), .o_fifo_level(lvl2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int s);
    case (s)
      0:       return txd0;
      1:       return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic logic busy(input int s);
    return (s == 2) ? busy2 : busy0;
  endfunction

  // 8-bit frame: start 0, data LSB first, optional parity bit, one stop bit.
  function automatic logic [11:0] f8(input logic [7:0] w, input logic pbit);
    logic [11:0] r;
    r = 12'(w) << 1;
    if (P == 1) r = r | (12'(pbit) << 9) | 12'h400;
    else        r = r | 12'h200;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int s, input int bound, output int waited);
    waited = 0;
    while (line(s) !== 1'b0 && waited < bound) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // pre < 0: wait for the start bit; otherwise we are already pre negedges into it.
  task automatic frame(input int s, input logic [11:0] ea, input logic [11:0] eb, input int n,
                       input string tag, input int pre, output int gap);
    gap = 0;
    if (pre < 0) wait_start(s, 400, gap);
    chk({tag, "_start"}, 32'(line(s)), 32'd0);
    tick((pre < 0) ? 5 : 5 - pre);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick(10);
      chk($sformatf("%s_b%0d", tag, i), 32'(line(s)), 32'(ea[i]));
      if (s == 0) chk($sformatf("%s_b%0d_odd", tag, i), 32'(txd1), 32'(eb[i]));
    end
  endtask

  // Called at the last stop-bit centre; busy must drop 5 clocks later.
  task automatic frame_len(input int s, input int n, input string tag);
    int cnt;
    cnt = 0;
    while (busy(s) !== 1'b0 && cnt < 300) begin
      tick(1);
      cnt++;
    end
    chk({tag, "_len"}, 32'(5 + 10 * (n - 1) + cnt), 32'(FLEN));
  endtask

  logic [7:0] words [5]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic       evenp [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int gap, lows;
    rst = 1'b1; rst2 = 1'b1; v = 1'b0; v2 = 1'b0; d = '0; d2 = '0;

    // 1: reset held for 3 clocks
    tick(3);
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_level", 32'(lvl0), 32'd0);
    chk("rst_odd", {28'd0, txd1, busy1, rdy1, 1'b0}, {28'd0, 4'b1010});
    chk("rst_odd_level", 32'(lvl1), 32'd0);
    chk("rst_72", {29'd0, txd2, busy2, rdy2}, {29'd0, 3'b101});
    chk("rst_72_level", 32'(lvl2), 32'd0);
    rst = 1'b0; rst2 = 1'b0;
    tick(2);

    // 2: single 0xA5, start bit two clocks after the push edge
    d = 8'hA5; v = 1'b1;
    tick(1);
    v = 1'b0;
    chk("lat_n0", 32'(txd0), 32'd1);
    chk("busy_rise", 32'(busy0), 32'd0);
    tick(1);
    chk("lat_n1", 32'(txd0), 32'd1);
    chk("busy_up", 32'(busy0), 32'd1);
    tick(1);
    chk("lat_n2", 32'(txd0), 32'd0);
    frame(0, f8(8'hA5, 1'b0), f8(8'hA5, 1'b1), NB8, "a5", 0, gap);
    frame_len(0, NB8, "a5");
    tick(20);
    chk("a5_idle", 32'(txd0), 32'd1);

    // 4: 0x07 parity check (even -> 1, odd -> 0 when enabled)
    d = 8'h07; v = 1'b1;
    tick(1);
    v = 1'b0;
    frame(0, f8(8'h07, 1'b1), f8(8'h07, 1'b0), NB8, "w07", -1, gap);
    chk("w07_latency", 32'(gap), 32'd2);
    frame_len(0, NB8, "w07");
    tick(10);

    // 3: five words with valid held high into a 4-deep FIFO
    v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = words[i];
      tick(1);
    end
    v = 1'b0;
    chk("full_level", 32'(lvl0), 32'd4);
    chk("full_ready", 32'(rdy0), 32'd0);
    frame(0, f8(words[0], evenp[0]), f8(words[0], ~evenp[0]), NB8, "q0", 2, gap);
    chk("full_hold_level", 32'(lvl0), 32'd4);
    chk("full_hold_ready", 32'(rdy0), 32'd0);
    for (int i = 1; i < 5; i++) begin
      frame(0, f8(words[i], evenp[i]), f8(words[i], ~evenp[i]), NB8, $sformatf("q%0d", i), -1, gap);
      chk($sformatf("q%0d_gap", i), 32'(gap), 32'd5);
      chk($sformatf("q%0d_busy", i), 32'(busy0), 32'd1);
      if (i == 1) begin
        chk("pop_level", 32'(lvl0), 32'd3);
        chk("pop_ready", 32'(rdy0), 32'd1);
      end
    end
    frame_len(0, NB8, "q4");
    chk("q_empty", 32'(lvl0), 32'd0);
    tick(10);

    // 5: reset during data bit 3 with two words queued
    d = 8'h00; v = 1'b1;
    tick(3);
    v = 1'b0;
    chk("ab_start", 32'(txd0), 32'd0);
    chk("ab_queued", 32'(lvl0), 32'd2);
    tick(45);
    chk("ab_bit3", 32'(txd0), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("ab_txd", 32'(txd0), 32'd1);
    chk("ab_level", 32'(lvl0), 32'd0);
    chk("ab_busy", 32'(busy0), 32'd0);
    chk("ab_ready", 32'(rdy0), 32'd1);
    lows = 0;
    repeat (300) begin
      tick(1);
      if (txd0 !== 1'b1) lows++;
    end
    chk("ab_silent", 32'(lows), 32'd0);
    chk("ab_busy_after", 32'(busy0), 32'd0);

    // 6: 7 data bits, 2 stop bits, 0x55
    d2 = 7'h55; v2 = 1'b1;
    tick(1);
    v2 = 1'b0;
    frame(2, (P == 1) ? 12'h6AA : 12'h3AA, 12'h000, NB72, "d7s2", -1, gap);
    chk("d7s2_latency", 32'(gap), 32'd2);
    frame_len(2, NB72, "d7s2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
